// File: rtl/tr_pkg.sv
// Shared constants for the TR synchroniser/filter: edge-history encodings
// and the default idle level of the active-low TR lines.
package tr_pkg;

  // {tr one cycle ago, tr now}
  typedef enum logic [1:0] {
    TR_EDGE_NONE_LO = 2'b00,
    TR_EDGE_RISE    = 2'b01,
    TR_EDGE_FALL    = 2'b10,
    TR_EDGE_NONE_HI = 2'b11
  } tr_edge_e;

  // TR is active-low, so the line idles high
  localparam logic TR_RST_LEVEL = 1'b1;

endpackage

// File: rtl/tr_chan.sv
// One TR channel: synchroniser, debounce, edge pulses/history and
// high-time measurement. ch_en low holds everything but width in reset.
module tr_chan
  import tr_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE    = 4,
  parameter int   CNT_W       = 16,
  parameter logic RST_LEVEL   = TR_RST_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tr_in,
  input  logic             ch_en,
  output logic             tr,
  output logic [1:0]       tr_edge,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] width,
  output logic             width_vld
);

  localparam logic [7:0]       DB_LAST = 8'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [7:0]             r_cnt;
  logic                   r_tr;
  tr_edge_e               r_edge;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_vld;
  logic [CNT_W-1:0]       r_hcnt;
  logic [CNT_W-1:0]       r_width;

  logic                   w_sample;
  logic                   w_flip;
  logic                   w_tr_next;
  logic [CNT_W-1:0]       w_hcnt_inc;

  assign w_sample   = r_sync[SYNC_STAGES-1];
  // a level change is accepted on the DEBOUNCE-th consecutive differing sample
  assign w_flip     = (w_sample != r_tr) && (r_cnt == DB_LAST);
  assign w_tr_next  = w_flip ? w_sample : r_tr;
  assign w_hcnt_inc = (r_hcnt == CNT_MAX) ? r_hcnt : r_hcnt + CNT_W'(1);

  // sync chain, debounce counter, filtered level, pulses and high counter
  always_ff @(posedge clk) begin
    if (!rst || !ch_en) begin
      r_sync <= {SYNC_STAGES{RST_LEVEL}};
      r_cnt  <= '0;
      r_tr   <= RST_LEVEL;
      r_edge <= tr_edge_e'({RST_LEVEL, RST_LEVEL});
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_vld  <= 1'b0;
      r_hcnt <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tr_in};
      // any sample matching the current level restarts the debounce window
      if (w_sample == r_tr || r_cnt == DB_LAST)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 8'd1;
      r_tr   <= w_tr_next;
      r_edge <= tr_edge_e'({r_edge[0], w_tr_next});
      r_rise <= w_flip &  w_sample;
      r_fall <= w_flip & ~w_sample;
      r_vld  <= w_flip & ~w_sample;
      // the rise edge is cycle 0 of the high period; later high cycles count up
      if (w_flip && w_sample)
        r_hcnt <= '0;
      else if (r_tr && !w_flip)
        r_hcnt <= w_hcnt_inc;
    end
  end

  // last completed high period; survives a channel disable, cleared by rst
  always_ff @(posedge clk) begin
    if (!rst)
      r_width <= '0;
    else if (ch_en && w_flip && !w_sample)
      r_width <= w_hcnt_inc;
  end

  assign tr        = r_tr;
  assign tr_edge   = r_edge;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign width     = r_width;
  assign width_vld = r_vld;

endmodule

// File: rtl/tr_filter_mc.sv
// Multi-channel TR synchroniser/filter: CH independent tr_chan instances
// with their outputs packed onto flat per-channel port slices.
module tr_filter_mc
  import tr_pkg::*;
#(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE    = 4,
  parameter int   CNT_W       = 16,
  parameter logic RST_LEVEL   = TR_RST_LEVEL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       tr_in,
  input  logic [CH-1:0]       ch_en,
  output logic [CH-1:0]       tr,
  output logic [2*CH-1:0]     tr_edge,
  output logic [CH-1:0]       rise,
  output logic [CH-1:0]       fall,
  output logic [CH*CNT_W-1:0] width,
  output logic [CH-1:0]       width_vld
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    tr_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE),
      .CNT_W       (CNT_W),
      .RST_LEVEL   (RST_LEVEL)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .tr_in     (tr_in[g]),
      .ch_en     (ch_en[g]),
      .tr        (tr[g]),
      .tr_edge   (tr_edge[2*g +: 2]),
      .rise      (rise[g]),
      .fall      (fall[g]),
      .width     (width[g*CNT_W +: CNT_W]),
      .width_vld (width_vld[g])
    );
  end

endmodule

// File: tb/tb_tr_filter_mc.sv
// Directed bench for tr_filter_mc: default 4-channel instance plus a
// 1-channel CNT_W=4 instance for width saturation.
module tb_tr_filter_mc;
  import tr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  tr_in, ch_en;
  logic [3:0]  tr, rise, fall, width_vld;
  logic [7:0]  tr_edge;
  logic [63:0] width;

  logic [0:0]  s_in, s_en, s_tr, s_rise, s_fall, s_vld;
  logic [1:0]  s_edge;
  logic [3:0]  s_width;

  int total = 0;
  int bad   = 0;
  logic flag;

  always #5 clk = ~clk;

  tr_filter_mc dut (
    .clk(clk), .rst(rst), .tr_in(tr_in), .ch_en(ch_en), .tr(tr),
    .tr_edge(tr_edge), .rise(rise), .fall(fall), .width(width),
    .width_vld(width_vld)
  );

  tr_filter_mc #(.CH(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .tr_in(s_in), .ch_en(s_en), .tr(s_tr),
    .tr_edge(s_edge), .rise(s_rise), .fall(s_fall), .width(s_width),
    .width_vld(s_vld)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance n edges, landing 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; ch_en = 4'hF; tr_in = 4'h0; s_in = 1'b1; s_en = 1'b1;
    tick(5);
    check("rst_tr",      tr,        64'hF);
    check("rst_edge",    tr_edge,   64'hFF);
    check("rst_rise",    rise,      64'h0);
    check("rst_fall",    fall,      64'h0);
    check("rst_vld",     width_vld, 64'h0);
    check("rst_width",   width,     64'h0);
    check("rst_s_width", s_width,   64'h0);

    // release with all lines idle high
    tr_in = 4'hF; rst = 1'b1;
    tick(3);

    // ch0 clean low pulse, 20 cycles
    tr_in[0] = 1'b0;
    tick(5);
    check("c0_pre_tr",   tr,   64'hF);
    check("c0_pre_fall", fall, 64'h0);
    tick(1);
    check("c0_fall",     fall,         64'h1);
    check("c0_tr",       tr,           64'hE);
    check("c0_edge",     tr_edge[1:0], TR_EDGE_FALL);
    check("c0_vld",      width_vld,    64'h1);
    check("c0_w_boot",   width[15:0],  64'd9);
    tick(1);
    check("c0_fall_end", fall,         64'h0);
    check("c0_edge_lo",  tr_edge[1:0], TR_EDGE_NONE_LO);
    tick(13);
    tr_in[0] = 1'b1;
    tick(5);
    check("c0_still_lo", tr[0], 64'h0);
    tick(1);
    check("c0_rise",     rise,         64'h1);
    check("c0_tr_hi",    tr,           64'hF);
    check("c0_edge_r",   tr_edge[1:0], TR_EDGE_RISE);

    // ch1 glitch of 3 samples: rejected
    tr_in[1] = 1'b0;
    tick(3);
    tr_in[1] = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (tr[1] !== 1'b1 || fall[1] !== 1'b0) flag = 1'b1;
    end
    check("g3_reject", flag, 64'h0);

    // ch1 glitch of 4 samples: accepted at edge 6, recovered at edge 10
    tr_in[1] = 1'b0;
    tick(4);
    tr_in[1] = 1'b1;
    tick(1);
    check("g4_pre_tr", tr[1], 64'h1);
    tick(1);
    check("g4_fall",   fall,  64'h2);
    check("g4_tr",     tr,    64'hD);
    tick(4);
    check("g4_rise",   rise,  64'h2);

    // ch2 high for exactly 37 cycles
    tr_in[2] = 1'b0;
    tick(8);
    tr_in[2] = 1'b1;
    tick(37);
    tr_in[2] = 1'b0;
    tick(5);
    check("w37_pre_vld", width_vld, 64'h0);
    tick(1);
    check("w37_vld",     width_vld,    64'h4);
    check("w37_fall",    fall,         64'h4);
    check("w37_width",   width[47:32], 64'd37);

    // CNT_W=4: 40-cycle high saturates at 15, 14-cycle high is exact
    s_in = 1'b0;
    tick(10);
    s_in = 1'b1;
    tick(40);
    s_in = 1'b0;
    tick(5);
    check("sat_pre_vld", s_vld, 64'h0);
    tick(1);
    check("sat_vld",     s_vld,   64'h1);
    check("sat_width",   s_width, 64'd15);
    s_in = 1'b1;
    tick(14);
    s_in = 1'b0;
    tick(6);
    check("w14_vld",     s_vld,   64'h1);
    check("w14_width",   s_width, 64'd14);

    // ch0 and ch3 fall together while ch1 bounces every 2 cycles
    tr_in[0] = 1'b0; tr_in[3] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) tr_in[1] = ~tr_in[1];
      tick(1);
    end
    check("sim_fall", fall, 64'h9);
    check("sim_tr",   tr,   64'h2);
    tr_in[1] = 1'b1;
    tick(3);
    check("sim_ch1",  tr[1], 64'h1);

    // ch2 disabled while low: back to idle, no pulses, width kept
    ch_en = 4'b1011;
    tick(1);
    check("en_tr",    tr,           64'h6);
    check("en_rise",  rise,         64'h0);
    check("en_vld",   width_vld,    64'h0);
    check("en_width", width[47:32], 64'd37);
    check("en_edge",  tr_edge[5:4], TR_EDGE_NONE_HI);
    ch_en = 4'hF;
    tick(5);
    check("ren_pre",   tr[2],        64'h1);
    tick(1);
    check("ren_fall",  fall,         64'h4);
    check("ren_width", width[47:32], 64'd6);

    // reset in the middle of ch1's debounce window
    tr_in[1] = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(1);
    check("mr_tr",    tr,    64'hF);
    check("mr_width", width, 64'h0);
    check("mr_fall",  fall,  64'h0);
    rst = 1'b1;
    tick(5);
    check("mr_pre_tr", tr,    64'hF);
    tick(1);
    check("mr_tr_lo",  tr,    64'h0);
    check("mr_fall_all", fall, 64'hF);
    check("mr_width6", width, 64'h0006_0006_0006_0006);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
